spi_master_xfer: RTL and testbench

Serial engine that sits directly downstream of the SPI register file. It accepts one parallel word per transfer through a valid/ready handshake and shifts it out MSB-first on MOSI in SPI mode 0 (CPOL=0, CPHA=0). It samples MISO simultaneously and returns the received word with a single-cycle valid pulse. The register file drives `tx_*` and consumes `tx_ready`, `rx_*` and `busy` as its DV/MISO status.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clk_div.sv | 51 +++++
 rtl/spi_master_xfer.sv | 135 +++++++++++++
 tb/tb_spi_master_xfer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master serial engine: FSM states, default
// sizing and the fixed bus mode (mode 0).
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } spi_state_e;

   localparam int W_SPI_DATA          = 32;
   localparam int SPI_CLK_DIV_DEFAULT = 4;

   // Mode is fixed; these only record the bus polarity/phase the engine implements.
   localparam logic CPOL = 1'b0;
   localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: toggles sclk every CLK_DIV enabled clk cycles and flags the
// edge it is about to make with a one-cycle rise/fall strobe.
module spi_clk_div
   import spi_pkg::*;
#(
   parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (CLK_DIV < 1) begin : g_bad_div
      $error("spi_clk_div: CLK_DIV must be >= 1");
   end

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;
   logic          tc;

   // Strobes coincide with the clk edge on which sclk_q actually toggles.
   assign tc       = en && (cnt_q == CW'(CLK_DIV - 1));
   assign rise_stb = tc && !sclk_q;
   assign fall_stb = tc && sclk_q;
   assign sclk     = sclk_q;

   always_comb begin
      cnt_d  = '0;
      sclk_d = CPOL;
      if (en) begin
         cnt_d  = tc ? '0 : cnt_q + CW'(1);
         sclk_d = tc ? ~sclk_q : sclk_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= CPOL;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_master_xfer.sv
// SPI mode-0 master: accepts a word on a valid/ready handshake, shifts it out
// MSB-first while sampling MISO, and returns the received word with a pulse.
module spi_master_xfer
   import spi_pkg::*;
#(
   parameter int W_DATA  = W_SPI_DATA,
   parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W_DATA-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [W_DATA-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs_n
);

   localparam int BW = (W_DATA > 1) ? $clog2(W_DATA) : 1;

   if (W_DATA < 2) begin : g_bad_width
      $error("spi_master_xfer: W_DATA must be >= 2");
   end
   if (CPOL != 1'b0 || CPHA != 1'b0) begin : g_bad_mode
      $error("spi_master_xfer: only SPI mode 0 is implemented");
   end

   spi_state_e        state_q, state_d;
   logic [W_DATA-1:0] tx_sr_q, tx_sr_d;
   logic [W_DATA-1:0] rx_sr_q, rx_sr_d;
   logic [W_DATA-1:0] rx_data_q, rx_data_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              mosi_q, mosi_d;
   logic              rx_valid_q, rx_valid_d;
   logic              tx_ready_q, tx_ready_d;
   logic              busy_q, busy_d;
   logic              cs_n_q, cs_n_d;
   logic              div_en, rise_stb, fall_stb;

   assign div_en = (state_q == SHIFT);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk      (clk),
      .rst      (rst),
      .en       (div_en),
      .sclk     (sclk),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   always_comb begin
      state_d    = state_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      bit_d      = bit_q;
      mosi_d     = mosi_q;
      rx_valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tx_valid) begin
               tx_sr_d = tx_data;
               mosi_d  = tx_data[W_DATA-1];
               bit_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (rise_stb) begin
               rx_sr_d = {rx_sr_q[W_DATA-2:0], miso};
            end
            // bit_q indexes the bit on the wire; its falling edge closes that bit.
            if (fall_stb) begin
               if (bit_q == BW'(W_DATA - 1)) begin
                  rx_data_d  = rx_sr_q;
                  rx_valid_d = 1'b1;
                  mosi_d     = 1'b0;
                  bit_d      = '0;
                  state_d    = DONE;
               end else begin
                  tx_sr_d = tx_sr_q << 1;
                  mosi_d  = tx_sr_d[W_DATA-1];
                  bit_d   = bit_q + BW'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Status outputs are registered copies of the upcoming state.
      tx_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
      cs_n_d     = (state_d != SHIFT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         bit_q      <= '0;
         mosi_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         cs_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         bit_q      <= bit_d;
         mosi_q     <= mosi_d;
         rx_valid_q <= rx_valid_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         cs_n_q     <= cs_n_d;
      end
   end

   assign tx_ready = tx_ready_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;
   assign mosi     = mosi_q;
   assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_xfer.sv
// Directed bench for spi_master_xfer: an 8-bit/CLK_DIV=1 instance and a
// default 32-bit/CLK_DIV=4 instance share clock, reset and the MISO driver.
module tb_spi_master_xfer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  tx_data8 = '0;
   logic        tx_valid8 = 1'b0;
   logic        tx_ready8, rx_valid8, busy8, sclk8, mosi8, miso8, cs_n8;
   logic [7:0]  rx_data8;

   logic [31:0] tx_data32 = '0;
   logic        tx_valid32 = 1'b0;
   logic        tx_ready32, rx_valid32, busy32, sclk32, mosi32, miso32, cs_n32;
   logic [31:0] rx_data32;

   logic loop8 = 1'b0;
   logic miso_drv = 1'b0;
   bit   scramble = 1'b0;

   assign miso8  = loop8 ? mosi8 : miso_drv;
   assign miso32 = miso_drv;

   int tests = 0;
   int fails = 0;

   spi_master_xfer #(.W_DATA(8), .CLK_DIV(1)) dut8 (
      .clk(clk), .rst(rst), .tx_data(tx_data8), .tx_valid(tx_valid8),
      .tx_ready(tx_ready8), .rx_data(rx_data8), .rx_valid(rx_valid8),
      .busy(busy8), .sclk(sclk8), .mosi(mosi8), .miso(miso8), .cs_n(cs_n8)
   );

   spi_master_xfer dut32 (
      .clk(clk), .rst(rst), .tx_data(tx_data32), .tx_valid(tx_valid32),
      .tx_ready(tx_ready32), .rx_data(rx_data32), .rx_valid(rx_valid32),
      .busy(busy32), .sclk(sclk32), .mosi(mosi32), .miso(miso32), .cs_n(cs_n32)
   );

   // One transfer on the selected instance. Cycle n=1 is the first negedge after
   // the accepting posedge; a mode-0 slave shifts miso after each falling sclk.
   task automatic xfer(input bit big, input logic [31:0] d, input logic [31:0] slv,
                       output logic [31:0] mbits, output int rxv_at, output int rxv_cnt,
                       output logic [31:0] rxd, output int rise1, output int rise2);
      int nb;
      int rises;
      logic [31:0] ssr;
      logic ps, cs;
      nb = big ? 32 : 8;
      mbits = '0; rxv_at = -1; rxv_cnt = 0; rxd = '0; rise1 = -1; rise2 = -1;
      rises = 0; ssr = slv; ps = 1'b0;
      @(negedge clk);
      tests++;
      if ((big ? tx_ready32 : tx_ready8) !== 1'b1) begin
         fails++;
         $display("FAIL xfer_ready: tx_ready=%b required 1", big ? tx_ready32 : tx_ready8);
      end
      if (big) begin tx_data32 = d; tx_valid32 = 1'b1; end
      else     begin tx_data8 = d[7:0]; tx_valid8 = 1'b1; end
      miso_drv = ssr[nb-1];
      @(negedge clk);
      tx_valid8 = 1'b0; tx_valid32 = 1'b0;
      for (int n = 1; n <= 600; n++) begin
         if (n > 1) @(negedge clk);
         if (scramble) begin
            tx_data8  = 8'($urandom);
            tx_data32 = $urandom;
         end
         cs = big ? sclk32 : sclk8;
         if (!ps && cs) begin
            rises++;
            mbits = {mbits[30:0], big ? mosi32 : mosi8};
            if (rises == 1) rise1 = n;
            if (rises == 2) rise2 = n;
         end
         if (ps && !cs) begin
            ssr = ssr << 1;
            miso_drv = ssr[nb-1];
         end
         if (big ? rx_valid32 : rx_valid8) begin
            rxv_cnt++;
            if (rxv_at < 0) begin
               rxv_at = n;
               rxd = big ? rx_data32 : {24'h0, rx_data8};
            end
         end
         ps = cs;
         if (rxv_at > 0 && n >= rxv_at + 3) break;
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      tests++;
      if ({tx_ready8, busy8, rx_valid8, rx_data8, sclk8, mosi8, cs_n8} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL reset_dut8: rdy/busy/rxv/rxd/sclk/mosi/csn=%b/%b/%b/%h/%b/%b/%b required 1/0/0/00/0/0/1",
                  tx_ready8, busy8, rx_valid8, rx_data8, sclk8, mosi8, cs_n8);
      end
      tests++;
      if ({tx_ready32, busy32, rx_valid32, rx_data32, sclk32, mosi32, cs_n32} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL reset_dut32: rdy/busy/rxv/rxd/sclk/mosi/csn=%b/%b/%b/%h/%b/%b/%b required 1/0/0/0/0/0/1",
                  tx_ready32, busy32, rx_valid32, rx_data32, sclk32, mosi32, cs_n32);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({tx_ready8, busy8, cs_n8, sclk8} !== 4'b1010) begin
         fails++;
         $display("FAIL idle_after_reset: rdy/busy/csn/sclk=%b required 1010", {tx_ready8, busy8, cs_n8, sclk8});
      end
   endtask

   task automatic test_loopback();
      logic [31:0] mb, rxd;
      int at, cnt, r1, r2;
      loop8 = 1'b1;
      xfer(1'b0, 32'hA5, 32'h0, mb, at, cnt, rxd, r1, r2);
      loop8 = 1'b0;
      tests++;
      if (mb[7:0] !== 8'hA5) begin fails++; $display("FAIL loop_mosi_seq: got %h required a5", mb[7:0]); end
      tests++;
      if (at !== 17) begin fails++; $display("FAIL loop_rxv_time: got %0d required 17", at); end
      tests++;
      if (rxd[7:0] !== 8'hA5) begin fails++; $display("FAIL loop_rx_data: got %h required a5", rxd[7:0]); end
      tests++;
      if (cnt !== 1) begin fails++; $display("FAIL loop_rxv_pulses: got %0d required 1", cnt); end
      tests++;
      if (r1 !== 2 || r2 !== 4) begin fails++; $display("FAIL loop_sclk_rise: got %0d,%0d required 2,4", r1, r2); end
   endtask

   task automatic test_default32();
      logic [31:0] mb, rxd;
      int at, cnt, r1, r2;
      xfer(1'b1, 32'h12345678, 32'hDEADBEEF, mb, at, cnt, rxd, r1, r2);
      tests++;
      if (rxd !== 32'hDEADBEEF) begin fails++; $display("FAIL d32_rx_data: got %h required deadbeef", rxd); end
      tests++;
      if (mb !== 32'h12345678) begin fails++; $display("FAIL d32_slave_capture: got %h required 12345678", mb); end
      tests++;
      if (at !== 257) begin fails++; $display("FAIL d32_rxv_time: got %0d required 257", at); end
      tests++;
      if (r1 !== 5) begin fails++; $display("FAIL d32_first_rise: got %0d required 5", r1); end
      tests++;
      if (r2 - r1 !== 8) begin fails++; $display("FAIL d32_sclk_period: got %0d required 8", r2 - r1); end
      tests++;
      if (cnt !== 1) begin fails++; $display("FAIL d32_rxv_pulses: got %0d required 1", cnt); end
   endtask

   task automatic test_back_to_back();
      int falls[2];
      int nfall, gap, early_rdy, first_rdy, nrx;
      int rx_at[2];
      logic [7:0] rx_d[2];
      logic [15:0] bits;
      logic pcs, ps;
      nfall = 0; gap = 0; early_rdy = 0; first_rdy = -1; nrx = 0; bits = '0;
      falls[0] = -1; falls[1] = -1; rx_at[0] = -1; rx_at[1] = -1; rx_d[0] = '0; rx_d[1] = '0;
      pcs = 1'b1; ps = 1'b0;
      loop8 = 1'b1;
      @(negedge clk);
      tx_data8 = 8'hF0; tx_valid8 = 1'b1;
      for (int n = 1; n <= 45; n++) begin
         @(negedge clk);
         if (n == 1) tx_data8 = 8'h3C;
         if (pcs && !cs_n8 && nfall < 2) begin
            falls[nfall] = n;
            nfall++;
            if (nfall == 2) tx_valid8 = 1'b0;
         end
         if (nfall == 1 && cs_n8 && !busy8) gap++;
         if (n <= 17 && tx_ready8) early_rdy++;
         if (tx_ready8 && first_rdy < 0) first_rdy = n;
         if (!ps && sclk8) bits = {bits[14:0], mosi8};
         if (rx_valid8 && nrx < 2) begin rx_at[nrx] = n; rx_d[nrx] = rx_data8; nrx++; end
         pcs = cs_n8; ps = sclk8;
      end
      tx_valid8 = 1'b0;
      loop8 = 1'b0;
      tests++;
      if (early_rdy !== 0 || first_rdy !== 18) begin
         fails++; $display("FAIL b2b_no_early_accept: early=%0d first_ready=%0d required 0,18", early_rdy, first_rdy);
      end
      tests++;
      if (falls[0] !== 1 || falls[1] !== 19) begin
         fails++; $display("FAIL b2b_csn_falls: got %0d,%0d required 1,19", falls[0], falls[1]);
      end
      tests++;
      if (gap !== 1) begin fails++; $display("FAIL b2b_idle_gap: got %0d required 1", gap); end
      tests++;
      if (bits !== 16'hF03C) begin fails++; $display("FAIL b2b_mosi_bits: got %h required f03c", bits); end
      tests++;
      if (rx_at[0] !== 17 || rx_at[1] !== 35 || rx_d[0] !== 8'hF0 || rx_d[1] !== 8'h3C) begin
         fails++;
         $display("FAIL b2b_rx: at %0d,%0d data %h,%h required 17,35 f0,3c", rx_at[0], rx_at[1], rx_d[0], rx_d[1]);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] mb, rxd;
      int at, cnt, r1, r2, rises, bad;
      logic ps;
      rises = 0; bad = 0; ps = 1'b0;
      @(negedge clk);
      tx_data8 = 8'hFF; tx_valid8 = 1'b1; miso_drv = 1'b1;
      @(negedge clk);
      tx_valid8 = 1'b0;
      for (int n = 0; n < 40 && rises < 3; n++) begin
         if (n > 0) @(negedge clk);
         if (!ps && sclk8) rises++;
         ps = sclk8;
      end
      tests++;
      if (rises !== 3 || busy8 !== 1'b1) begin
         fails++; $display("FAIL mid_setup: rises=%0d busy=%b required 3,1", rises, busy8);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({tx_ready8, busy8, rx_valid8, rx_data8, sclk8, mosi8, cs_n8} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL mid_reset_values: rdy/busy/rxv/rxd/sclk/mosi/csn=%b/%b/%b/%h/%b/%b/%b required 1/0/0/00/0/0/1",
                  tx_ready8, busy8, rx_valid8, rx_data8, sclk8, mosi8, cs_n8);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (rx_valid8 !== 1'b0 || rx_data8 !== 8'h00) bad++;
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL mid_no_rx: %0d bad cycles required 0", bad); end
      xfer(1'b0, 32'h81, 32'h42, mb, at, cnt, rxd, r1, r2);
      tests++;
      if (mb[7:0] !== 8'h81 || rxd[7:0] !== 8'h42 || at !== 17) begin
         fails++; $display("FAIL mid_next_xfer: mosi %h rx %h at %0d required 81 42 17", mb[7:0], rxd[7:0], at);
      end
   endtask

   task automatic test_stability();
      logic [31:0] mb, rxd;
      int at, cnt, r1, r2;
      loop8 = 1'b1;
      scramble = 1'b1;
      xfer(1'b0, 32'h5A, 32'h0, mb, at, cnt, rxd, r1, r2);
      scramble = 1'b0;
      loop8 = 1'b0;
      tests++;
      if (mb[7:0] !== 8'h5A) begin fails++; $display("FAIL stab_mosi: got %h required 5a", mb[7:0]); end
      tests++;
      if (rxd[7:0] !== 8'h5A) begin fails++; $display("FAIL stab_rx: got %h required 5a", rxd[7:0]); end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_default32();
      test_back_to_back();
      test_reset_mid();
      test_stability();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
